// File: rtl/sqrt_datapath.sv
// Datapath for a digit-by-digit (two bits per step) integer square root.
// An external controller sequences the ld / sh / ld_tmp / lda2 / r0 / done
// strobes; the datapath reports the trial sign (msb) and the
// counter-exhausted flag (z) back to it.
module sqrt_datapath #(
  parameter  int WIDTH = 16,
  localparam int RW    = WIDTH / 2,
  localparam int MW    = RW + 2,
  localparam int TW    = RW + 3,
  localparam int CW    = $clog2(RW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] radicand,
  input  logic             ld,
  input  logic             sh,
  input  logic             ld_tmp,
  input  logic             lda2,
  input  logic             r0,
  input  logic             done,
  output logic             msb,
  output logic             z,
  output logic [RW-1:0]    root,
  output logic [MW-1:0]    rem,
  output logic             result_valid
);

  logic [WIDTH-1:0] A_q, A_d;
  logic [MW-1:0]    R_q, R_d;
  logic [RW-1:0]    Q_q, Q_d;
  logic [TW-1:0]    TMP_q, TMP_d;
  logic [CW-1:0]    CNT_q, CNT_d;
  logic [RW-1:0]    root_q, root_d;
  logic [MW-1:0]    rem_q, rem_d;
  logic             rv_q, rv_d;
  logic [TW-1:0]    trial;

  // Trial subtraction. The controller shifts Q before capturing the trial,
  // so Q[RW-1:1] is the partial root of the previous step and the
  // subtrahend is that root with "01" appended (4*root_prev + 1).
  always_comb begin
    trial = {1'b0, R_q} - {2'b00, Q_q[RW-1:1], 2'b01};
  end

  // Next-state selection: ld dominates, then sh, then lda2/r0;
  // ld_tmp and done act alongside whichever of those applies.
  always_comb begin
    A_d    = A_q;
    R_d    = R_q;
    Q_d    = Q_q;
    TMP_d  = TMP_q;
    CNT_d  = CNT_q;
    root_d = root_q;
    rem_d  = rem_q;
    rv_d   = rv_q;
    if (ld) begin
      A_d   = radicand;
      R_d   = '0;
      Q_d   = '0;
      TMP_d = '0;
      CNT_d = CW'(RW);
      rv_d  = 1'b0;
    end else begin
      if (sh) begin
        R_d   = {R_q[MW-3:0], A_q[WIDTH-1:WIDTH-2]};
        A_d   = {A_q[WIDTH-3:0], 2'b00};
        Q_d   = {Q_q[RW-2:0], 1'b0};
        CNT_d = (CNT_q == '0) ? '0 : CNT_q - 1'b1;
      end else begin
        if (lda2) R_d = TMP_q[MW-1:0];
        if (r0)   Q_d[0] = 1'b1;
      end
      if (ld_tmp) TMP_d = trial;
      if (done) begin
        root_d = Q_q;
        rem_d  = R_q;
        rv_d   = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      A_q    <= '0;
      R_q    <= '0;
      Q_q    <= '0;
      TMP_q  <= '0;
      CNT_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
      rv_q   <= 1'b0;
    end else begin
      A_q    <= A_d;
      R_q    <= R_d;
      Q_q    <= Q_d;
      TMP_q  <= TMP_d;
      CNT_q  <= CNT_d;
      root_q <= root_d;
      rem_q  <= rem_d;
      rv_q   <= rv_d;
    end
  end

  // Status and result outputs come straight from registers.
  always_comb begin
    msb          = TMP_q[TW-1];
    z            = (CNT_q == '0);
    root         = root_q;
    rem          = rem_q;
    result_valid = rv_q;
  end

endmodule
